// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state type, hold default and index-to-pattern decode for onehot_decoder_hold.
package decoder_pkg;
    typedef enum logic {IDLE, ACTIVE} dec_state_t;
    localparam int DEC_HOLD_DEFAULT = 2;
    localparam int DEC_MAX_N = 64;
    // Callers size-cast the result down to their own N.
    function automatic logic [DEC_MAX_N-1:0] f_decode(input int unsigned idx, input logic thermo);
        logic [DEC_MAX_N-1:0] one;
        one = DEC_MAX_N'(1) << idx;
        return thermo ? (one | (one - DEC_MAX_N'(1))) : one;
    endfunction
endpackage

// File: rtl/decoder_hold_counter.sv
// decoder_hold_counter: loadable down-counter that stops at zero and flags the final hold cycle.
module decoder_hold_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last
);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - CW'(1);
    assign last = cnt == CW'(1);
endmodule

// File: rtl/onehot_decoder_hold.sv
// onehot_decoder_hold: registered binary-to-one-hot decoder with valid/ready handshake and HOLD-cycle output hold.
// Define ONEHOT_DECODER_THERMO_EN to drive thermometer code out_onehot[k:0] instead of one-hot.
module onehot_decoder_hold import decoder_pkg::*; #(
    parameter int N    = 4,
    parameter int W    = $clog2(N),
    parameter int HOLD = DEC_HOLD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_idx,
    output logic         in_ready,
    output logic [N-1:0] out_onehot,
    output logic         out_valid,
    output logic         err
);
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [W:0] N_LIM = (W + 1)'(N);
`ifdef ONEHOT_DECODER_THERMO_EN
    localparam logic THERMO = 1'b1;
`else
    localparam logic THERMO = 1'b0;
`endif
    dec_state_t state;
    logic last, xfer, in_range, good;
    logic [N-1:0] dec;
    assign in_ready = state == IDLE || last;
    assign xfer = in_valid && in_ready;
    assign in_range = {1'b0, in_idx} < N_LIM;
    assign good = xfer && in_range;
    assign dec = N'(f_decode(32'(in_idx), THERMO));
    decoder_hold_counter #(.CW(CW)) u_cnt (
        .clk(clk),
        .rst(rst),
        .load(good),
        .load_val(CW'(HOLD)),
        .last(last)
    );
    // An out-of-range transfer only raises err; the hold still winds down normally.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            out_onehot <= '0;
            out_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            err <= xfer && !in_range;
            if (good) begin
                state <= ACTIVE;
                out_onehot <= dec;
                out_valid <= 1'b1;
            end else if (state == ACTIVE && last) begin
                state <= IDLE;
                out_onehot <= '0;
                out_valid <= 1'b0;
            end
        end
endmodule
